// File: rtl/itcm_fch_slv_if.sv
// rtl/itcm_fch_slv_if.sv - fetch request/response packet types and handshake interfaces
package itcm_fch_pkg;
    localparam int RV_PC_SIZE = 32;
    localparam int RV_IR_SIZE = 32;

    typedef struct packed {
        logic [RV_PC_SIZE-1:0] pc;
    } fch_req_pkt_t;

    typedef struct packed {
        logic [RV_IR_SIZE-1:0] ir;
    } fch_rsp_pkt_t;
endpackage

interface fch_req_if_t;
    import itcm_fch_pkg::*;
    logic         vld;
    logic         rdy;
    fch_req_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface fch_rsp_if_t;
    import itcm_fch_pkg::*;
    logic         vld;
    logic         rdy;
    fch_rsp_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/itcm_fch_slv.sv
// rtl/itcm_fch_slv.sv - instruction TCM fetch responder with 2-entry response FIFO
// Optional misaligned-pc check enabled by FCH_MISALIGN_CHK_EN.
module itcm_fch_slv
    import itcm_fch_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    fch_req_if_t.slv                       fch_req_slv,
    fch_rsp_if_t.mst                       fch_rsp_mst,
    input  logic                           ld_vld,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [RV_IR_SIZE-1:0]          ld_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [RV_IR_SIZE-1:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0]      rd_idx;
    logic                  req_hsk;
    logic                  rsp_hsk;
    logic                  accept;
    logic                  inflight;
    logic [RV_IR_SIZE-1:0] rd_data;
    logic [RV_IR_SIZE-1:0] rd_word;
    logic [RV_IR_SIZE-1:0] fifo_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ;
    logic                  unused_pc;

    assign rd_idx    = fch_req_slv.pkt.pc[IDX_W+1:2];
    assign unused_pc = ^{fch_req_slv.pkt.pc[RV_PC_SIZE-1:IDX_W+2], fch_req_slv.pkt.pc[1:0]};

    assign req_hsk = fch_req_slv.vld & fch_req_slv.rdy;
    assign rsp_hsk = fch_rsp_mst.vld & fch_rsp_mst.rdy;
    // rdy is forced high in reset, so acceptance must be gated separately
    assign accept  = req_hsk & rst_n;

    assign occ             = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, rsp_hsk};
    assign fch_req_slv.rdy = ~rst_n | (occ < 3'd2);

    // Array is not reset; nonblocking update gives read-first on index collision
    always_ff @(posedge clk) begin
        if (ld_vld) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept) begin
            rd_data <= mem[rd_idx];
        end
    end

`ifdef FCH_MISALIGN_CHK_EN
    logic misal_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            misal_q <= |fch_req_slv.pkt.pc[1:0];
        end
    end

    assign rd_word = misal_q ? '0 : rd_data;
`else
    assign rd_word = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            inflight <= accept;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rsp_hsk) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, rsp_hsk})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && inflight) begin
            fifo_q[wr_ptr] <= rd_word;
        end
    end

    assign fch_rsp_mst.vld    = (fifo_cnt != 2'd0);
    assign fch_rsp_mst.pkt.ir = fch_rsp_mst.vld ? fifo_q[rd_ptr] : '0;
endmodule

// File: tb/tb_itcm_fch_slv.sv
// tb/tb_itcm_fch_slv.sv - directed self-checking bench for itcm_fch_slv
module tb_itcm_fch_slv;
    import itcm_fch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ld_vld;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    int          vec_cnt;
    int          err_cnt;

    fch_req_if_t req_if ();
    fch_rsp_if_t rsp_if ();

    itcm_fch_slv #(.DEPTH_WORDS(1024)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_req_slv (req_if),
        .fch_rsp_mst (rsp_if),
        .ld_vld      (ld_vld),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        ld_vld  = 1'b1;
        ld_addr = idx;
        ld_data = data;
        tick();
        ld_vld  = 1'b0;
    endtask

    task automatic read_one(input logic [31:0] pc, output logic [31:0] ir, output logic ok);
        int n;
        n = 0;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = pc;
        rsp_if.rdy    = 1'b1;
        #1;
        while (!req_if.rdy && n < 20) begin
            tick();
            #1;
            n++;
        end
        tick();
        req_if.vld = 1'b0;
        #1;
        while (!rsp_if.vld && n < 20) begin
            tick();
            #1;
            n++;
        end
        ir = rsp_if.pkt.ir;
        ok = (n < 20);
        tick();
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = 32'h0;
        rsp_if.rdy    = 1'b1;
        tick();
        vec_cnt++;
        if (req_if.rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_req_rdy: got %b expected 1", req_if.rdy);
        end
        vec_cnt++;
        if (rsp_if.vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_rsp_vld: got %b expected 0", rsp_if.vld);
        end
        tick();
        rst_n      = 1'b1;
        req_if.vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vec_cnt++;
            if (rsp_if.vld !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_no_accept cycle %0d: rsp vld got %b expected 0", k, rsp_if.vld);
            end
            tick();
        end
    endtask

    task automatic test_basic;
        logic [31:0] exp_ir [4];
        exp_ir[0] = 32'h11;
        exp_ir[1] = 32'h22;
        exp_ir[2] = 32'h33;
        exp_ir[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            load(10'(i), exp_ir[i]);
        end
        rsp_if.rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                req_if.vld    = 1'b1;
                req_if.pkt.pc = 32'(4 * k);
            end else begin
                req_if.vld = 1'b0;
            end
            #1;
            if (k < 4) begin
                vec_cnt++;
                if (req_if.rdy !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL basic_req_rdy cycle %0d: got %b expected 1", k, req_if.rdy);
                end
            end
            vec_cnt++;
            if (rsp_if.vld !== (k >= 2 && k <= 5)) begin
                err_cnt++;
                $display("FAIL basic_rsp_vld cycle %0d: got %b expected %b", k, rsp_if.vld, (k >= 2 && k <= 5));
            end
            if (k >= 2 && k <= 5) begin
                vec_cnt++;
                if (rsp_if.pkt.ir !== exp_ir[k-2]) begin
                    err_cnt++;
                    $display("FAIL basic_ir cycle %0d: got %h expected %h", k, rsp_if.pkt.ir, exp_ir[k-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int acc;
        acc        = 0;
        rsp_if.rdy = 1'b0;
        req_if.vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_if.pkt.pc = (acc == 0) ? 32'd8 : 32'd12;
            #1;
            vec_cnt++;
            if (req_if.rdy !== (k < 2)) begin
                err_cnt++;
                $display("FAIL bp_req_rdy cycle %0d: got %b expected %b", k, req_if.rdy, (k < 2));
            end
            if (k >= 2) begin
                vec_cnt++;
                if (rsp_if.vld !== 1'b1 || rsp_if.pkt.ir !== 32'h33) begin
                    err_cnt++;
                    $display("FAIL bp_hold cycle %0d: got vld %b ir %h expected vld 1 ir 00000033", k, rsp_if.vld, rsp_if.pkt.ir);
                end
            end
            if (req_if.rdy) acc++;
            tick();
        end
        vec_cnt++;
        if (acc !== 2) begin
            err_cnt++;
            $display("FAIL bp_accepts: got %0d expected 2", acc);
        end
        req_if.vld = 1'b0;
        rsp_if.rdy = 1'b1;
        #1;
        vec_cnt++;
        if (req_if.rdy !== 1'b1 || rsp_if.vld !== 1'b1 || rsp_if.pkt.ir !== 32'h33) begin
            err_cnt++;
            $display("FAIL bp_first_pop: got rdy %b vld %b ir %h expected rdy 1 vld 1 ir 00000033", req_if.rdy, rsp_if.vld, rsp_if.pkt.ir);
        end
        tick();
        #1;
        vec_cnt++;
        if (rsp_if.vld !== 1'b1 || rsp_if.pkt.ir !== 32'h44) begin
            err_cnt++;
            $display("FAIL bp_second_pop: got vld %b ir %h expected vld 1 ir 00000044", rsp_if.vld, rsp_if.pkt.ir);
        end
        tick();
        #1;
        vec_cnt++;
        if (rsp_if.vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_drained: got vld %b expected 0", rsp_if.vld);
        end
        tick();
    endtask

    task automatic test_wrap;
        logic [31:0] ir;
        logic        ok;
        read_one(32'(4 * 1024 + 8), ir, ok);
        vec_cnt++;
        if (!ok || ir !== 32'h33) begin
            err_cnt++;
            $display("FAIL wrap: got ok %b ir %h expected ok 1 ir 00000033", ok, ir);
        end
    endtask

    task automatic test_read_first;
        logic [31:0] ir;
        logic        ok;
        int          n;
        load(10'd5, 32'hAA);
        ld_vld        = 1'b1;
        ld_addr       = 10'd5;
        ld_data       = 32'hBB;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = 32'd20;
        rsp_if.rdy    = 1'b1;
        #1;
        vec_cnt++;
        if (req_if.rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL rf_req_rdy: got %b expected 1", req_if.rdy);
        end
        tick();
        ld_vld     = 1'b0;
        req_if.vld = 1'b0;
        n = 0;
        #1;
        while (!rsp_if.vld && n < 20) begin
            tick();
            #1;
            n++;
        end
        vec_cnt++;
        if (n >= 20 || rsp_if.pkt.ir !== 32'hAA) begin
            err_cnt++;
            $display("FAIL rf_old_data: got ir %h after %0d cycles expected 000000aa", rsp_if.pkt.ir, n);
        end
        tick();
        read_one(32'd20, ir, ok);
        vec_cnt++;
        if (!ok || ir !== 32'hBB) begin
            err_cnt++;
            $display("FAIL rf_new_data: got ok %b ir %h expected ok 1 ir 000000bb", ok, ir);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] ir;
        logic        ok;
        logic [31:0] exp;
`ifdef FCH_MISALIGN_CHK_EN
        exp = 32'h0;
`else
        exp = 32'h22;
`endif
        read_one(32'h6, ir, ok);
        vec_cnt++;
        if (!ok || ir !== exp) begin
            err_cnt++;
            $display("FAIL misalign: got ok %b ir %h expected ok 1 ir %h", ok, ir, exp);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] ir;
        logic        ok;
        rsp_if.rdy    = 1'b0;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = 32'd0;
        #1;
        vec_cnt++;
        if (req_if.rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mr_accept_a: got rdy %b expected 1", req_if.rdy);
        end
        tick();
        req_if.pkt.pc = 32'd4;
        #1;
        vec_cnt++;
        if (req_if.rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mr_accept_b: got rdy %b expected 1", req_if.rdy);
        end
        tick();
        rst_n         = 1'b0;
        req_if.pkt.pc = 32'd8;
        #1;
        vec_cnt++;
        if (req_if.rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mr_rdy_in_reset: got %b expected 1", req_if.rdy);
        end
        tick();
        rst_n      = 1'b1;
        req_if.vld = 1'b0;
        rsp_if.rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vec_cnt++;
            if (rsp_if.vld !== 1'b0) begin
                err_cnt++;
                $display("FAIL mr_discard cycle %0d: got vld %b ir %h expected vld 0", k, rsp_if.vld, rsp_if.pkt.ir);
            end
            tick();
        end
        read_one(32'd12, ir, ok);
        vec_cnt++;
        if (!ok || ir !== 32'h44) begin
            err_cnt++;
            $display("FAIL mr_after_reset: got ok %b ir %h expected ok 1 ir 00000044", ok, ir);
        end
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        ld_vld        = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        req_if.vld    = 1'b0;
        req_if.pkt.pc = '0;
        rsp_if.rdy    = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_read_first();
        test_misalign();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/itcm_fch_slv.md
ITCM_FCH_SLV -- requirements
Module: itcm_fch_slv

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, instruction-array depth in 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Local constant IDX_W SHALL be log2(DEPTH_WORDS), the array index width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous and active-low: sampled only on posedge clk, asserted when 0.
REQ-005 fch_req_slv  fch_req_if_t.slv  vld (in, 1), rdy (out, 1), pkt.pc (in, RV_PC_SIZE)  fetch-request responder side.
REQ-006 fch_rsp_mst  fch_rsp_if_t.mst  vld (out, 1), rdy (in, 1), pkt.ir (out, RV_IR_SIZE)  fetch-response initiator side.
REQ-007 ld_vld  in  1  program-load write strobe.
REQ-008 ld_addr  in  IDX_W  program-load word index.
REQ-009 ld_data  in  RV_IR_SIZE  program-load write data.

Function
REQ-010 Request handshake req_hsk = fch_req_slv.vld & fch_req_slv.rdy; response handshake rsp_hsk = fch_rsp_mst.vld & fch_rsp_mst.rdy.
REQ-011 Read index SHALL be pc[IDX_W+1:2]; higher pc bits ignored, so addresses wrap modulo DEPTH_WORDS.
REQ-012 Array read is synchronous: req_hsk in cycle N sets inflight flag in N+1, with read data available in N+1.
REQ-013 Read data SHALL enter a 2-entry in-order response FIFO at end of cycle N+1; FIFO head is fch_rsp_mst.pkt.ir.
REQ-014 fch_rsp_mst.vld = FIFO non-empty, driven from flops only; earliest response is cycle N+2 after acceptance.
REQ-015 fch_req_slv.rdy = (fifo_cnt + inflight - rsp_hsk) < 2; sustained throughput 1 request/cycle when fch_rsp_mst.rdy stays high.
REQ-016 fch_req_slv.rdy SHALL NOT depend combinationally on fch_req_slv.vld.
REQ-017 FIFO push and pop in the same cycle SHALL leave fifo_cnt unchanged, with order preserved; FIFO SHALL never overflow or underflow.
REQ-018 pkt.ir and vld SHALL hold stable while vld=1 and rdy=0.
REQ-019 Responses SHALL return in request order, exactly one per accepted request.
REQ-020 ld_vld=1 writes ld_data to array[ld_addr] at posedge; loads need no handshake and SHALL never stall fetch.
REQ-021 A load and a read to the same index in the same cycle SHALL return old data (read-first).

Reset
REQ-022 With rst_n=0 at posedge: fifo_cnt=0, inflight=0, FIFO pointers=0, fch_rsp_mst.vld=0.
REQ-023 During reset fch_req_slv.rdy SHALL read 1, but no request is accepted while rst_n=0.
REQ-024 Reset mid-operation SHALL discard inflight reads and buffered responses; no response for them is ever produced.
REQ-025 Array contents SHALL NOT be reset; loads during reset SHALL still write.

Configuration
REQ-026 Macro FCH_MISALIGN_CHK_EN defined: a request with pc[1:0]!=0 returns ir=32'h0000_0000 (illegal encoding) in place of array data, with identical latency and ordering.
REQ-027 Macro FCH_MISALIGN_CHK_EN undefined: pc[1:0] ignored; the word at pc[IDX_W+1:2] is returned.

Verification
REQ-028 Load array[0..3]=32'h11,32'h22,32'h33,32'h44; issue pc 0,4,8,12 back-to-back with rsp rdy=1 -> vld in cycles 2..5 after first accept, ir 11,22,33,44.
REQ-029 Hold rsp rdy=0, drive req vld continuously -> exactly 2 accepts, then req rdy=0; raise rsp rdy -> responses in order and req rdy=1 in the same cycle as the first pop.
REQ-030 pc=4*DEPTH_WORDS+8 -> returns array[2].
REQ-031 Load index 5 with 32'hAA, read pc 20 in the same cycle as a load of 32'hBB to index 5 -> ir=32'hAA; a re-read returns 32'hBB.
REQ-032 pc=32'h6 -> ir=32'h0 with FCH_MISALIGN_CHK_EN defined; ir=array[1] without it.
REQ-033 Two requests accepted, rst_n=0 for one cycle before their responses -> vld stays 0 and no stale ir appears; the next request returns correct data.
